// File: rtl/pipelined_prefix_adder.sv
// Pipelined Sklansky parallel-prefix adder/subtractor with valid/ready on both sides.
// Pipeline: operand register (A, B', carry-in) -> stage 0 (bitwise g/p with the
// carry-in folded in as position 0) -> ceil(L/PIPE_LEVELS) prefix groups. Each group
// ends in a register. The last group's register is out_*, and it also carries the sum
// and the flags.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both high.
// in_ready = ~(out_valid & ~out_ready). When the pipeline stalls, every register holds.
// Otherwise every stage advances, and bubbles advance along with valid data.
module pipelined_prefix_adder #(
  parameter int WIDTH       = 16,
  parameter int PIPE_LEVELS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int L = $clog2(WIDTH);
  localparam int S = (L + PIPE_LEVELS - 1) / PIPE_LEVELS;

  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // Operand register: mode is applied here, so B' and the carry-in are final.
  logic             cap_v;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_c;

  // Prefix stage registers. Position j of g/p covers bit j-1; position 0 is the
  // carry-in (g = cin, p = 0). After all levels, position i is the carry into bit i.
  logic             st_v [S];
  logic [WIDTH-1:0] st_a [S];
  logic [WIDTH-1:0] st_b [S];
  logic [WIDTH-1:0] st_g [S];
  logic [WIDTH-1:0] st_p [S];

  // Combinational outputs of each prefix group (index s feeds register s, S feeds out_*).
  logic [WIDTH-1:0] nx_g [1:S];
  logic [WIDTH-1:0] nx_p [1:S];

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_n;
  logic             cout_n;
  logic             ovf_n;

  // Sklansky levels for each group. At level l, every position with bit (l-1) set
  // absorbs the top position of the lower half-block. That source is not written
  // at the same level, so an in-place ascending update is exact.
  always_comb begin
    logic [WIDTH-1:0] gt;
    logic [WIDTH-1:0] pt;
    int               k;
    gt = '0;
    pt = '0;
    k  = 0;
    for (int s = 1; s <= S; s++) begin
      gt = st_g[s-1];
      pt = st_p[s-1];
      for (int l = (s - 1) * PIPE_LEVELS + 1; l <= s * PIPE_LEVELS; l++) begin
        if (l <= L) begin
          for (int j = 0; j < WIDTH; j++) begin
            if (((j >> (l - 1)) & 1) == 1) begin
              k     = ((j >> (l - 1)) << (l - 1)) - 1;
              gt[j] = gt[j] | (pt[j] & gt[k]);
              pt[j] = pt[j] & pt[k];
            end
          end
        end
      end
      nx_g[s] = gt;
      nx_p[s] = pt;
    end
  end

  // Sum and flags from the completed carry vector; the MSB carry-out is one extra cell.
  always_comb begin
    carry  = nx_g[S];
    sum_n  = st_a[S-1] ^ st_b[S-1] ^ carry;
    cout_n = (st_a[S-1][WIDTH-1] & st_b[S-1][WIDTH-1]) |
             ((st_a[S-1][WIDTH-1] | st_b[S-1][WIDTH-1]) & carry[WIDTH-1]);
    ovf_n  = carry[WIDTH-1] ^ cout_n;
  end

  // Pipeline advance. Valid bits move on every non-stalled edge. Data registers load
  // only behind valid data, so the outputs keep their last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_v <= 1'b0;
      cap_a <= '0;
      cap_b <= '0;
      cap_c <= 1'b0;
      for (int s = 0; s < S; s++) begin
        st_v[s] <= 1'b0;
        st_a[s] <= '0;
        st_b[s] <= '0;
        st_g[s] <= '0;
        st_p[s] <= '0;
      end
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (adv) begin
      cap_v <= in_valid;
      if (in_valid) begin
        cap_a <= in_a;
        cap_b <= in_sub ? ~in_b : in_b;
        cap_c <= in_sub | in_cin;
      end

      st_v[0] <= cap_v;
      if (cap_v) begin
        st_a[0] <= cap_a;
        st_b[0] <= cap_b;
        st_g[0] <= {cap_a[WIDTH-2:0] & cap_b[WIDTH-2:0], cap_c};
        st_p[0] <= {cap_a[WIDTH-2:0] | cap_b[WIDTH-2:0], 1'b0};
      end

      for (int s = 1; s < S; s++) begin
        st_v[s] <= st_v[s-1];
        if (st_v[s-1]) begin
          st_a[s] <= st_a[s-1];
          st_b[s] <= st_b[s-1];
          st_g[s] <= nx_g[s];
          st_p[s] <= nx_p[s];
        end
      end

      out_valid <= st_v[S-1];
      if (st_v[S-1]) begin
        out_sum  <= sum_n;
        out_cout <= cout_n;
        out_ovf  <= ovf_n;
        out_zero <= (sum_n == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder. The main instance is WIDTH=16, PIPE_LEVELS=2 (LAT=3).
// Two side instances run random streams: WIDTH=13/PIPE_LEVELS=1 (LAT=5) and
// WIDTH=32/PIPE_LEVELS=5 (LAT=2).
// Every accepted operation is pushed to an expected queue computed with plain
// integer arithmetic. Every output transfer pops the queue and compares.
module tb_pipelined_prefix_adder;

  localparam int W = 16;
  localparam int NOPS = 10000;
  localparam int NX = 4000;

  logic         clk;
  logic         rst_n;
  logic         rst_x;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  int           n_vec = 0;
  int           n_err = 0;
  logic [63:0]  exp_q[$];
  bit           rnd;
  bit           x_done [2];

  pipelined_prefix_adder #(.WIDTH(W), .PIPE_LEVELS(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {zero, ovf, cout, sum}, built with integer arithmetic.
  function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] mask, ua, ub, full, res, r;
    longint      sa, sb, sres, lim;
    logic        cout, ovf;
    mask = (64'd1 << w) - 64'd1;
    ua   = a & mask;
    ub   = b & mask;
    lim  = longint'(64'd1 << (w - 1));
    sa   = ua[w-1] ? longint'(ua) - 2 * lim : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - 2 * lim : longint'(ub);
    if (sub) begin
      res  = (ua - ub) & mask;
      cout = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + 64'(cin);
      res  = full & mask;
      cout = (full >> w) != 64'd0;
      sres = sa + sb + longint'(cin);
    end
    ovf      = (sres >= lim) || (sres < -lim);
    r        = res;
    r[w]     = cout;
    r[w+1]   = ovf;
    r[w+2]   = (res == 64'd0);
    return r;
  endfunction

  // Operand picker biased toward the corner values.
  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return mask;
      2:       return 64'd1 << (w - 1);
      3:       return mask >> 1;
      4:       return 64'd1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  // Scoreboard for the main instance, sampled on the falling edge.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(out_sum), 64'hDEAD_0000);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'({out_zero, out_ovf, out_cout, out_sum}), e);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(W, 64'(in_a), 64'(in_b), in_cin, in_sub));
    end
  end

  // Driver: present one op and hold it until it is accepted. With scramble set,
  // the operands are changed while the DUT is not ready.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input bit scramble);
    int g;
    g        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        in_a   = W'(pick(W));
        in_b   = W'(pick(W));
        in_cin = 1'($urandom_range(0, 1));
        in_sub = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // One op on an idle pipe. Checks the exact latency, the result, the fall of
  // out_valid and that the data holds afterwards.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic [W-1:0] e_sum,
                         input logic e_cout, input logic e_ovf, input logic e_zero);
    send(a, b, cin, sub, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_lat"}, 64'(out_valid), (k == 3) ? 64'd1 : 64'd0);
    end
    check({tag, "_sum"}, 64'(out_sum), 64'(e_sum));
    check({tag, "_cout"}, 64'(out_cout), 64'(e_cout));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(e_ovf));
    check({tag, "_zero"}, 64'(out_zero), 64'(e_zero));
    @(posedge clk);
    #1;
    check({tag, "_vfall"}, 64'(out_valid), 64'd0);
    check({tag, "_hold"}, 64'(out_sum), 64'(e_sum));
  endtask

  initial begin
    int          g;
    logic [63:0] head;
    rst_n     = 1'b0;
    rst_x     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    rnd       = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
    #10;
    rst_n = 1'b1;
    rst_x = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Wrap-around add, then subtract with overflow and a negative difference.
    run_one("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_one("sub_neg",  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Streaming: 10 back-to-back ops; results arrive on 10 consecutive cycles.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(W'(pick(W)), W'(pick(W)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
          check("stream_ready", 64'(in_ready), 64'd1);
        end
      end
      begin
        repeat (4) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
          #1;
          check("stream_valid", 64'(out_valid), 64'd1);
          @(posedge clk);
        end
        #1;
        check("stream_end", 64'(out_valid), 64'd0);
      end
    join

    // Backpressure: hold out_ready low for 5 cycles once the first result shows.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(W'(pick(W)), W'(pick(W)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      end
      begin
        g = 0;
        while (!out_valid && g < 20) begin
          @(posedge clk);
          #1;
          g++;
        end
        check("bp_valid", 64'(out_valid), 64'd1);
        head = (exp_q.size() != 0) ? exp_q[0] : 64'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_hold", 64'({out_zero, out_ovf, out_cout, out_sum}), head);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    check("bp_drain", 64'(exp_q.size()), 64'd0);

    // Reset mid-flight with two ops in the pipe.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    send(16'h3333, 16'h0001, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    check("rst_async_sum", 64'(out_sum), 64'd0);
    check("rst_async_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      check("rst_no_stale", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    run_one("post_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);

    // Random ops with random gaps, random out_ready and operands changed while stalled.
    rnd = 1'b1;
    fork
      begin
        for (int i = 0; i < NOPS; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          send(W'(pick(W)), W'(pick(W)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        rnd = 1'b0;
      end
      begin
        while (rnd) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    check("rand_drain", 64'(exp_q.size()), 64'd0);

    g = 0;
    while (!(x_done[0] && x_done[1]) && g < 60000) begin
      @(posedge clk);
      g++;
    end
    check("side_done", 64'(x_done[0] && x_done[1]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Side instances: other widths and level groupings, random streams plus latency.
  for (genvar k = 0; k < 2; k++) begin : g_cfg
    localparam int    WK = (k == 0) ? 13 : 32;
    localparam int    PK = (k == 0) ? 1 : 5;
    localparam int    LK = (k == 0) ? 5 : 2;
    localparam string TG = (k == 0) ? "w13" : "w32";

    logic          vi, ri, vo, ro, ci, si, co, ov, zo;
    logic [WK-1:0] ai, bi, so;
    logic [63:0]   q[$];
    bit            xr;

    pipelined_prefix_adder #(.WIDTH(WK), .PIPE_LEVELS(PK)) u_dut (
      .clk       (clk),
      .rst_n     (rst_x),
      .in_valid  (vi),
      .in_ready  (ri),
      .in_a      (ai),
      .in_b      (bi),
      .in_cin    (ci),
      .in_sub    (si),
      .out_valid (vo),
      .out_ready (ro),
      .out_sum   (so),
      .out_cout  (co),
      .out_ovf   (ov),
      .out_zero  (zo)
    );

    always @(negedge clk) begin
      logic [63:0] e;
      if (rst_x) begin
        if (vo && ro) begin
          if (q.size() == 0) begin
            check({TG, "_unexpected"}, 64'(so), 64'hDEAD_0000);
          end else begin
            e = q.pop_front();
            check({TG, "_result"}, 64'({zo, ov, co, so}), e);
          end
        end
        if (vi && ri) q.push_back(model(WK, 64'(ai), 64'(bi), ci, si));
      end
    end

    initial begin
      int g;
      int cnt;
      vi = 1'b0;
      ai = '0;
      bi = '0;
      ci = 1'b0;
      si = 1'b0;
      ro = 1'b1;
      xr = 1'b0;
      wait (rst_x);
      @(posedge clk);
      #1;
      // Latency of a single op on an empty pipe.
      vi = 1'b1;
      ai = WK'(pick(WK));
      bi = WK'(pick(WK));
      @(negedge clk);
      @(posedge clk);
      #1;
      vi  = 1'b0;
      cnt = 0;
      do begin
        @(posedge clk);
        #1;
        cnt++;
      end while (!vo && cnt < 20);
      check({TG, "_latency"}, 64'(cnt), 64'(LK));
      repeat (3) @(posedge clk);
      #1;
      xr = 1'b1;
      fork
        begin
          for (int i = 0; i < NX; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              vi = 1'b0;
              @(posedge clk);
              #1;
            end
            vi = 1'b1;
            ai = WK'(pick(WK));
            bi = WK'(pick(WK));
            ci = 1'($urandom_range(0, 1));
            si = 1'($urandom_range(0, 1));
            g  = 0;
            @(negedge clk);
            while (!ri && g < 200) begin
              @(posedge clk);
              #1;
              @(negedge clk);
              g++;
            end
            if (g >= 200) check({TG, "_accept_timeout"}, 64'd0, 64'd1);
            @(posedge clk);
            #1;
          end
          vi = 1'b0;
          xr = 1'b0;
        end
        begin
          while (xr) begin
            @(posedge clk);
            #1;
            ro = ($urandom_range(0, 3) != 0);
          end
          ro = 1'b1;
        end
      join
      repeat (LK + 10) @(posedge clk);
      #1;
      check({TG, "_drain"}, 64'(q.size()), 64'd0);
      x_done[k] = 1'b1;
    end
  end

endmodule
